// File: rtl/pwm_drive_scheduler_if.sv
// Command/status bundle between the PWM drive scheduler and its surroundings.
// The master side supplies host/RC/pause commands; the slave side returns the width and status.
interface pwm_drive_scheduler_if;
  logic [7:0] host_width;
  logic       host_strobe;
  logic       rc_valid;
  logic [7:0] rc_width;
  logic       pause;
  logic [7:0] width;
  logic       frame_tick;
  logic [1:0] source;
  logic       at_target;

  modport master (
    output host_width, host_strobe, rc_valid, rc_width, pause,
    input  width, frame_tick, source, at_target
  );

  modport slave (
    input  host_width, host_strobe, rc_valid, rc_width, pause,
    output width, frame_tick, source, at_target
  );
endinterface

// File: rtl/pwm_drive_scheduler.sv
// Picks the width command for one PWM channel from host, RC or neutral, slews it once per
// frame, and owns the frame timebase; the source output doubles as the visible FSM state.
module pwm_drive_scheduler #(
  parameter int FRAME_CYCLES        = 5100,
  parameter int NEUTRAL             = 127,
  parameter int SLEW_STEP           = 8,
  parameter int HOST_TIMEOUT_FRAMES = 25,
  parameter int RC_OVERRIDE         = 1
) (
  input  logic                  clk_255kHz,
  input  logic                  reset,
  pwm_drive_scheduler_if.slave  bus
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int TW = $clog2(HOST_TIMEOUT_FRAMES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(HOST_TIMEOUT_FRAMES);
  localparam logic [7:0]    NEUTRAL_W  = 8'(NEUTRAL);
  localparam logic [7:0]    STEP_W     = 8'(SLEW_STEP);

  localparam logic [1:0] SRC_NEUTRAL = 2'd0;
  localparam logic [1:0] SRC_HOST    = 2'd1;
  localparam logic [1:0] SRC_RC      = 2'd2;
  localparam logic [1:0] SRC_PAUSED  = 2'd3;

  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;
  logic [7:0]    host_target_q, host_target_d;
  logic          host_stale_q, host_stale_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    src_q, src_d;
  logic [7:0]    width_q, width_d;

  logic [7:0]        target;
  logic signed [8:0] diff;
  logic [8:0]        mag;
  logic [7:0]        slewed;

  always_comb begin
    target = NEUTRAL_W;
    case (src_q)
      SRC_HOST: target = host_target_q;
      SRC_RC:   target = bus.rc_width;
      default:  target = NEUTRAL_W;
    endcase
  end

  // The clamp to target is what keeps the ramp inside 0..255; no wrap can occur.
  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, width_q});
    mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {1'b0, STEP_W}) begin
      slewed = target;
    end else if (diff[8]) begin
      slewed = width_q - STEP_W;
    end else begin
      slewed = width_q + STEP_W;
    end
  end

  always_comb begin
    count_d = (count_q == LAST_COUNT) ? '0 : count_q + 1'b1;
    tick_d  = (count_d == LAST_COUNT);

    host_target_d = host_target_q;
    host_stale_d  = host_stale_q;
    tmo_d         = tmo_q;
    if (bus.host_strobe) begin
      host_target_d = bus.host_width;
      host_stale_d  = 1'b0;
      tmo_d         = '0;
    end else if (tick_q) begin
      if (tmo_q != TMO_MAX) tmo_d = tmo_q + 1'b1;
      if (tmo_d == TMO_MAX) host_stale_d = 1'b1;
    end

    if (bus.pause) begin
      src_d = SRC_PAUSED;
    end else if (bus.rc_valid && ((RC_OVERRIDE != 0) || host_stale_q)) begin
      src_d = SRC_RC;
    end else if (!host_stale_q) begin
      src_d = SRC_HOST;
    end else begin
      src_d = SRC_NEUTRAL;
    end

    // Width only moves on the tick edge so it is stable when the generator latches at count 0.
    if (src_q == SRC_PAUSED) begin
      width_d = NEUTRAL_W;
    end else if (tick_q) begin
      width_d = slewed;
    end else begin
      width_d = width_q;
    end
  end

  always_ff @(posedge clk_255kHz) begin
    if (reset) begin
      count_q       <= '0;
      tick_q        <= 1'b0;
      host_target_q <= NEUTRAL_W;
      host_stale_q  <= 1'b1;
      tmo_q         <= '0;
      src_q         <= SRC_NEUTRAL;
      width_q       <= NEUTRAL_W;
    end else begin
      count_q       <= count_d;
      tick_q        <= tick_d;
      host_target_q <= host_target_d;
      host_stale_q  <= host_stale_d;
      tmo_q         <= tmo_d;
      src_q         <= src_d;
      width_q       <= width_d;
    end
  end

  assign bus.width      = width_q;
  assign bus.frame_tick = tick_q;
  assign bus.source     = src_q;
  assign bus.at_target  = (width_q == target);

endmodule

// File: tb/tb_pwm_drive_scheduler.sv
// Bench for pwm_drive_scheduler: directed scenarios plus random traffic against a frame-level
// reference model; two short-frame instances (RC override on/off) and one default-timing instance.
module tb_pwm_drive_scheduler;
  localparam int F = 32;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] host_width;
  logic       host_strobe;
  logic       rc_valid;
  logic [7:0] rc_width;
  logic       pause;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_drive_scheduler_if bus_a();
  pwm_drive_scheduler_if bus_b();
  pwm_drive_scheduler_if bus_c();

  assign bus_a.host_width = host_width;  assign bus_a.host_strobe = host_strobe;
  assign bus_a.rc_valid = rc_valid;      assign bus_a.rc_width = rc_width;
  assign bus_a.pause = pause;
  assign bus_b.host_width = host_width;  assign bus_b.host_strobe = host_strobe;
  assign bus_b.rc_valid = rc_valid;      assign bus_b.rc_width = rc_width;
  assign bus_b.pause = pause;
  assign bus_c.host_width = host_width;  assign bus_c.host_strobe = host_strobe;
  assign bus_c.rc_valid = rc_valid;      assign bus_c.rc_width = rc_width;
  assign bus_c.pause = pause;

  pwm_drive_scheduler #(.FRAME_CYCLES(F), .RC_OVERRIDE(1)) dut_a (
    .clk_255kHz(clk), .reset(rst), .bus(bus_a));
  pwm_drive_scheduler #(.FRAME_CYCLES(F), .RC_OVERRIDE(0)) dut_b (
    .clk_255kHz(clk), .reset(rst), .bus(bus_b));
  pwm_drive_scheduler dut_c (
    .clk_255kHz(clk), .reset(rst), .bus(bus_c));

  // Reference model: frame position, frames since the last host command, chosen source, width.
  typedef struct {
    int pos; bit tick; int frames; bit stale; int htgt; int src; int width;
  } model_t;
  model_t ma, mb;

  function automatic int model_target(model_t m, int rcw);
    if (m.src == 1) return m.htgt;
    if (m.src == 2) return rcw;
    return 127;
  endfunction

  function automatic int slew(int w, int t);
    if (t - w > 8) return w + 8;
    if (w - t > 8) return w - 8;
    return t;
  endfunction

  function automatic model_t model_next(model_t m, bit ov, bit r, bit strobe, int hw,
                                        bit rcv, int rcw, bit pz);
    model_t n = m;
    if (r) begin
      n.pos = 0; n.tick = 0; n.frames = 0; n.stale = 1; n.htgt = 127; n.src = 0; n.width = 127;
      return n;
    end
    if (m.src == 3) n.width = 127;
    else if (m.tick) n.width = slew(m.width, model_target(m, rcw));
    if (pz) n.src = 3;
    else if (rcv && (ov || m.stale)) n.src = 2;
    else if (!m.stale) n.src = 1;
    else n.src = 0;
    if (strobe) begin
      n.htgt = hw; n.stale = 0; n.frames = 0;
    end else if (m.tick) begin
      n.frames = (m.frames < 25) ? m.frames + 1 : 25;
      if (n.frames >= 25) n.stale = 1;
    end
    n.pos = (m.pos + 1) % F;
    n.tick = (n.pos == F - 1);
    return n;
  endfunction

  function automatic logic [11:0] model_obs(model_t m, int rcw);
    return {8'(m.width), 2'(m.src), m.tick, (m.width == model_target(m, rcw))};
  endfunction

  always @(posedge clk) begin
    ma <= model_next(ma, 1'b1, rst, host_strobe, int'(host_width), rc_valid, int'(rc_width), pause);
    mb <= model_next(mb, 1'b0, rst, host_strobe, int'(host_width), rc_valid, int'(rc_width), pause);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic next_frame();
    int n = 0;
    while (!bus_a.frame_tick && n < 4 * F) begin
      step();
      n++;
    end
    if (!bus_a.frame_tick) begin
      tests_run++; fails++;
      $display("FAIL frame_wait: no frame_tick within %0d cycles", 4 * F);
    end
    step();
  endtask

  task automatic pulse_host(input logic [7:0] w);
    host_width = w;
    host_strobe = 1'b1;
    step();
    host_strobe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; host_width = 8'd0; host_strobe = 1'b0;
    rc_valid = 1'b0; rc_width = 8'd0; pause = 1'b0;
    step(); step();
    tests_run++;
    if ({bus_a.width, bus_a.source, bus_a.frame_tick, bus_a.at_target} !== {8'd127, 2'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_a: got w=%0d src=%0d tick=%0d at=%0d want w=127 src=0 tick=0 at=1",
               bus_a.width, bus_a.source, bus_a.frame_tick, bus_a.at_target);
    end
    tests_run++;
    if ({bus_c.width, bus_c.source, bus_c.frame_tick, bus_c.at_target} !== {8'd127, 2'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_c: got w=%0d src=%0d tick=%0d at=%0d want w=127 src=0 tick=0 at=1",
               bus_c.width, bus_c.source, bus_c.frame_tick, bus_c.at_target);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame_tick();
    int ticks_a = 0;
    for (int k = 1; k <= 10199; k++) begin
      step();
      if (k <= 5099 && bus_a.frame_tick) ticks_a++;
      if (k == 5098 || k == 5099 || k == 5100 || k == 10199) begin
        tests_run++;
        if (bus_c.frame_tick !== ((k == 5099 || k == 10199) ? 1'b1 : 1'b0)) begin
          fails++;
          $display("FAIL frame_tick_5100 cycle %0d: got %0d", k, bus_c.frame_tick);
        end
      end
    end
    tests_run++;
    if (ticks_a != 5099 / F) begin
      fails++;
      $display("FAIL frame_tick_short: got %0d ticks want %0d", ticks_a, 5099 / F);
    end
    tests_run++;
    if ({bus_c.width, bus_c.source} !== {8'd127, 2'd0}) begin
      fails++;
      $display("FAIL idle_neutral: got w=%0d src=%0d want 127/0", bus_c.width, bus_c.source);
    end
  endtask

  task automatic test_host_ramp();
    next_frame();
    pulse_host(8'd255);
    step();
    tests_run++;
    if (bus_a.source !== 2'd1) begin
      fails++; $display("FAIL host_source: got %0d want 1", bus_a.source);
    end
    for (int k = 1; k <= 16; k++) begin
      next_frame();
      tests_run++;
      if (bus_a.width !== 8'((127 + 8 * k > 255) ? 255 : 127 + 8 * k) ||
          bus_a.at_target !== (k == 16)) begin
        fails++;
        $display("FAIL host_ramp frame %0d: got w=%0d at=%0d want w=%0d at=%0d", k, bus_a.width,
                 bus_a.at_target, (127 + 8 * k > 255) ? 255 : 127 + 8 * k, (k == 16));
      end
    end
  endtask

  task automatic test_host_timeout();
    for (int k = 17; k <= 25; k++) begin
      next_frame();
      tests_run++;
      if (bus_a.source !== 2'd1 || bus_a.width !== 8'd255) begin
        fails++;
        $display("FAIL host_hold frame %0d: got src=%0d w=%0d want 1/255", k, bus_a.source, bus_a.width);
      end
    end
    step();
    tests_run++;
    if (bus_a.source !== 2'd0) begin
      fails++; $display("FAIL host_stale_source: got %0d want 0", bus_a.source);
    end
    for (int k = 1; k <= 16; k++) begin
      next_frame();
      tests_run++;
      if (bus_a.width !== 8'(255 - 8 * k)) begin
        fails++; $display("FAIL stale_ramp frame %0d: got %0d want %0d", k, bus_a.width, 255 - 8 * k);
      end
    end
    tests_run++;
    if (bus_a.at_target !== 1'b1) begin
      fails++; $display("FAIL stale_at_target: got %0d want 1", bus_a.at_target);
    end
  endtask

  task automatic test_rc_arbitration();
    next_frame();
    pulse_host(8'd200);
    for (int k = 1; k <= 10; k++) begin
      next_frame();
      pulse_host(8'd200);
    end
    tests_run++;
    if (bus_a.width !== 8'd200 || bus_b.width !== 8'd200) begin
      fails++; $display("FAIL host_200: got a=%0d b=%0d want 200", bus_a.width, bus_b.width);
    end
    rc_width = 8'd0; rc_valid = 1'b1;
    step();
    tests_run++;
    if (bus_a.source !== 2'd2 || bus_b.source !== 2'd1) begin
      fails++; $display("FAIL rc_source: got a=%0d b=%0d want 2/1", bus_a.source, bus_b.source);
    end
    for (int k = 1; k <= 25; k++) begin
      next_frame();
      pulse_host(8'd200);
      tests_run++;
      if (bus_a.width !== 8'(200 - 8 * k) || bus_b.width !== 8'd200 || bus_b.source !== 2'd1) begin
        fails++;
        $display("FAIL rc_ramp frame %0d: got a=%0d b=%0d bsrc=%0d want a=%0d b=200 bsrc=1",
                 k, bus_a.width, bus_b.width, bus_b.source, 200 - 8 * k);
      end
    end
    rc_valid = 1'b0;
    step();
    tests_run++;
    if (bus_a.source !== 2'd1) begin
      fails++; $display("FAIL rc_drop_source: got %0d want 1", bus_a.source);
    end
    for (int k = 1; k <= 25; k++) begin
      next_frame();
      pulse_host(8'd200);
      tests_run++;
      if (bus_a.width !== 8'(8 * k)) begin
        fails++; $display("FAIL rc_return frame %0d: got %0d want %0d", k, bus_a.width, 8 * k);
      end
    end
  endtask

  task automatic test_pause();
    next_frame();
    pulse_host(8'd255);
    for (int k = 1; k <= 2; k++) begin
      next_frame();
      pulse_host(8'd255);
    end
    pause = 1'b1;
    step();
    tests_run++;
    if (bus_a.source !== 2'd3 || bus_a.width !== 8'd216) begin
      fails++; $display("FAIL pause_enter: got src=%0d w=%0d want 3/216", bus_a.source, bus_a.width);
    end
    step();
    tests_run++;
    if (bus_a.width !== 8'd127 || bus_b.width !== 8'd127 || bus_a.at_target !== 1'b1) begin
      fails++; $display("FAIL pause_neutral: got a=%0d b=%0d at=%0d", bus_a.width, bus_b.width, bus_a.at_target);
    end
    for (int k = 1; k <= 3; k++) begin
      next_frame();
      pulse_host(8'd255);
      tests_run++;
      if (bus_a.width !== 8'd127 || bus_a.source !== 2'd3) begin
        fails++; $display("FAIL pause_hold frame %0d: got w=%0d src=%0d", k, bus_a.width, bus_a.source);
      end
    end
    pause = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      next_frame();
      pulse_host(8'd255);
      tests_run++;
      if (bus_a.width !== 8'(127 + 8 * k) || bus_a.source !== 2'd1) begin
        fails++;
        $display("FAIL pause_release frame %0d: got w=%0d src=%0d want %0d/1", k, bus_a.width, bus_a.source, 127 + 8 * k);
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    int n = 0;
    while (!bus_a.frame_tick && n < 4 * F) begin
      step();
      n++;
    end
    tests_run++;
    if (!bus_a.frame_tick) begin
      fails++; $display("FAIL reset_mid_wait: no frame_tick within %0d cycles", 4 * F);
    end
    rst = 1'b1; host_width = 8'd99; host_strobe = 1'b1;
    step();
    tests_run++;
    if ({bus_a.width, bus_a.source, bus_a.frame_tick, bus_a.at_target} !== {8'd127, 2'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid_ramp: got w=%0d src=%0d tick=%0d at=%0d want 127/0/0/1",
               bus_a.width, bus_a.source, bus_a.frame_tick, bus_a.at_target);
    end
    rst = 1'b0; host_strobe = 1'b0;
    next_frame();
    next_frame();
    tests_run++;
    if (bus_a.width !== 8'd127 || bus_a.source !== 2'd0) begin
      fails++; $display("FAIL reset_drops_strobe: got w=%0d src=%0d want 127/0", bus_a.width, bus_a.source);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      host_strobe = ($urandom_range(0, 19) == 0);
      host_width = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) rc_valid = ~rc_valid;
      if ($urandom_range(0, 7) == 0) rc_width = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) pause = ~pause;
      step();
      tests_run++;
      if ({bus_a.width, bus_a.source, bus_a.frame_tick, bus_a.at_target} !== model_obs(ma, int'(rc_width))) begin
        fails++;
        $display("FAIL random_a cycle %0d: got %h want %h", i,
                 {bus_a.width, bus_a.source, bus_a.frame_tick, bus_a.at_target}, model_obs(ma, int'(rc_width)));
      end
      tests_run++;
      if ({bus_b.width, bus_b.source, bus_b.frame_tick, bus_b.at_target} !== model_obs(mb, int'(rc_width))) begin
        fails++;
        $display("FAIL random_b cycle %0d: got %h want %h", i,
                 {bus_b.width, bus_b.source, bus_b.frame_tick, bus_b.at_target}, model_obs(mb, int'(rc_width)));
      end
    end
    rst = 1'b0; host_strobe = 1'b0; pause = 1'b0; rc_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_tick();
    test_host_ramp();
    test_host_timeout();
    test_rc_arbitration();
    test_pause();
    test_reset_mid_ramp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
